fb_pattern_writer: RTL



---
 rtl/fbw_pkg.sv | 24 ++
 rtl/fb_pattern_gen.sv | 39 +++
 rtl/fb_pattern_writer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/fbw_pkg.sv
// Shared types and helpers for the framebuffer pattern writer.
// Contents: FSM state enum, pattern mode codes, pixel packing function.
// No ports; imported by fb_pattern_writer and fb_pattern_gen.
package fbw_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Mode 3 is reserved and falls through to solid in the generator.
  localparam logic [1:0] MODE_SOLID = 2'd0;
  localparam logic [1:0] MODE_GRAD  = 2'd1;
  localparam logic [1:0] MODE_GRID  = 2'd2;

  // Framebuffer word layout: unused top byte, then R, G, B.
  function automatic logic [31:0] pack_pixel(input logic [7:0] r,
                                             input logic [7:0] g,
                                             input logic [7:0] b);
    return {8'h00, r, g, b};
  endfunction

endpackage

// File: rtl/fb_pattern_gen.sv
// Test-pattern pixel generator: (mode, color, x, y) -> 32-bit framebuffer word.
// Latency: purely combinational. Backpressure: none, stateless.
// Ports: mode_i (pattern select), color_i {R,G,B}, x_i/y_i pixel coords, pix_o packed word.
module fb_pattern_gen
  import fbw_pkg::*;
#(
  parameter int XW = 10,
  parameter int YW = 9
) (
  input  logic [1:0]    mode_i,
  input  logic [23:0]   color_i,
  input  logic [XW-1:0] x_i,
  input  logic [YW-1:0] y_i,
  output logic [31:0]   pix_o
);

  // Only the low byte of each coordinate matters for any pattern; the
  // 8-bit sum gives the truncated (x+y) value directly.
  logic [7:0] x8;
  logic [7:0] y8;
  logic [7:0] sum8;
  logic       on_line;

  assign x8      = 8'(x_i);
  assign y8      = 8'(y_i);
  assign sum8    = x8 + y8;
  assign on_line = (x8[3:0] == 4'd0) || (y8[3:0] == 4'd0);

  always_comb begin
    pix_o = pack_pixel(color_i[23:16], color_i[15:8], color_i[7:0]);
    case (mode_i)
      MODE_GRAD: pix_o = pack_pixel(x8, y8, sum8);
      MODE_GRID: pix_o = on_line ? pack_pixel(color_i[23:16], color_i[15:8], color_i[7:0])
                                 : 32'h0;
      default:   pix_o = pack_pixel(color_i[23:16], color_i[15:8], color_i[7:0]);
    endcase
  end

endmodule

// File: rtl/fb_pattern_writer.sv
// Wishbone master that fills a linear 32bpp framebuffer with a generated test pattern.
// Latency: stb rises the cycle after start; one word per clock while ack is held high.
// Backpressure: stb/adr/dat held until ack; abort only takes effect after the pending ack.
// Ports: wshb_clk_i/wshb_rst_i (sync active-high), wshb_*_o master outputs, wshb_ack_i,
//        start_i/mode_i/color_i/abort_i control, busy_o/done_o/aborted_o status.
module fb_pattern_writer
  import fbw_pkg::*;
#(
  parameter int          HDISP    = 800,
  parameter int          VDISP    = 480,
  parameter logic [31:0] BASE_ADR = 32'h0
) (
  input  logic        wshb_clk_i,
  input  logic        wshb_rst_i,
  output logic        wshb_cyc_o,
  output logic        wshb_stb_o,
  output logic        wshb_we_o,
  output logic [3:0]  wshb_sel_o,
  output logic [2:0]  wshb_cti_o,
  output logic [1:0]  wshb_bte_o,
  output logic [31:0] wshb_adr_o,
  output logic [31:0] wshb_dat_ms_o,
  input  logic        wshb_ack_i,
  input  logic        start_i,
  input  logic [1:0]  mode_i,
  input  logic [23:0] color_i,
  input  logic        abort_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        aborted_o
);

  localparam int XW = (HDISP > 1) ? $clog2(HDISP) : 1;
  localparam int YW = (VDISP > 1) ? $clog2(VDISP) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(HDISP - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(VDISP - 1);

  state_e        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [31:0]   adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic [1:0]    mode_q, mode_d;
  logic [23:0]   color_q, color_d;
  logic          abort_q, abort_d;
  logic          cyc_q, cyc_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          aborted_q, aborted_d;

  logic [1:0]    gen_mode;
  logic [23:0]   gen_color;
  logic [XW-1:0] gen_x;
  logic [YW-1:0] gen_y;
  logic [31:0]   gen_pix;
  logic          last_pix;

  // Generator always looks at the pixel that will be loaded next: (0,0)
  // with the live mode/color when starting, otherwise the raster successor.
  always_comb begin
    gen_mode  = mode_q;
    gen_color = color_q;
    gen_x     = '0;
    gen_y     = '0;
    if (state_q == IDLE) begin
      gen_mode  = mode_i;
      gen_color = color_i;
    end else if (x_q == X_LAST) begin
      gen_y = y_q + YW'(1);
    end else begin
      gen_x = x_q + XW'(1);
      gen_y = y_q;
    end
  end

  fb_pattern_gen #(
    .XW(XW),
    .YW(YW)
  ) u_gen (
    .mode_i (gen_mode),
    .color_i(gen_color),
    .x_i    (gen_x),
    .y_i    (gen_y),
    .pix_o  (gen_pix)
  );

  assign last_pix = (x_q == X_LAST) && (y_q == Y_LAST);

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    mode_d    = mode_q;
    color_d   = color_q;
    abort_d   = abort_q;
    cyc_d     = cyc_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (start_i) begin
          state_d = WRITE;
          mode_d  = mode_i;
          color_d = color_i;
          x_d     = '0;
          y_d     = '0;
          adr_d   = BASE_ADR;
          dat_d   = gen_pix;
          cyc_d   = 1'b1;
          busy_d  = 1'b1;
        end
      end
      WRITE: begin
        if (abort_i) abort_d = 1'b1;
        if (wshb_ack_i) begin
          // An abort seen with this ack still lets the acked word count.
          if (last_pix || abort_q || abort_i) begin
            state_d   = DONE;
            cyc_d     = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            aborted_d = abort_q | abort_i;
          end else begin
            x_d   = gen_x;
            y_d   = gen_y;
            adr_d = adr_q + 32'd4;
            dat_d = gen_pix;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wshb_clk_i) begin
    if (wshb_rst_i) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      adr_q     <= 32'h0;
      dat_q     <= 32'h0;
      mode_q    <= MODE_SOLID;
      color_q   <= 24'h0;
      abort_q   <= 1'b0;
      cyc_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      mode_q    <= mode_d;
      color_q   <= color_d;
      abort_q   <= abort_d;
      cyc_q     <= cyc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  // Single-beat classic cycles only: cyc/stb/we move together.
  assign wshb_cyc_o    = cyc_q;
  assign wshb_stb_o    = cyc_q;
  assign wshb_we_o     = cyc_q;
  assign wshb_sel_o    = 4'hF;
  assign wshb_cti_o    = 3'b000;
  assign wshb_bte_o    = 2'b00;
  assign wshb_adr_o    = adr_q;
  assign wshb_dat_ms_o = dat_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign aborted_o     = aborted_q;

endmodule
